// File: rtl/mfp_ahb_lite_pkg.sv
// Shared AHB-Lite codes and default-slave state encodings
// for the mfp_ahb_lite interconnect.
package mfp_ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

endpackage

// File: rtl/mfp_ahb_lite_default_slave.sv
// Default slave: two-cycle ERROR for unmapped transfers.
// MFP_AHB_LITE_INTERCONNECT_TIMEOUT_EN adds a stalled-slave timeout.
module mfp_ahb_lite_default_slave
    import mfp_ahb_lite_pkg::*;
`ifdef MFP_AHB_LITE_INTERCONNECT_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 1024
)
`endif
(
    input  logic HCLK,
    input  logic HRESETn,
    input  logic hready,
    input  logic err_req,
`ifdef MFP_AHB_LITE_INTERCONNECT_TIMEOUT_EN
    input  logic slave_stall,
    output logic timeout,
    output logic timed_out,
`endif
    output logic ds_hready,
    output logic ds_hresp
);

    ds_state_t state;

`ifdef MFP_AHB_LITE_INTERCONNECT_TIMEOUT_EN
    logic [15:0] cnt;

    // Fires on the last permitted stall cycle
    assign timeout = slave_stall
                  && (cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt       <= '0;
            timed_out <= 1'b0;
        end else if (!slave_stall) begin
            cnt <= '0;
        end else if (timeout) begin
            cnt       <= '0;
            timed_out <= 1'b1;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= DS_IDLE;
            ds_hready <= 1'b1;
            ds_hresp  <= HRESP_OKAY;
        end else
`ifdef MFP_AHB_LITE_INTERCONNECT_TIMEOUT_EN
        if (timeout) begin
            state     <= DS_ERR1;
            ds_hready <= 1'b0;
            ds_hresp  <= HRESP_ERROR;
        end else
`endif
        begin
            unique case (state)
                DS_ERR1: begin
                    state     <= DS_ERR2;
                    ds_hready <= 1'b1;
                    ds_hresp  <= HRESP_ERROR;
                end
                DS_IDLE, DS_ERR2: begin
                    if (hready && err_req) begin
                        state     <= DS_ERR1;
                        ds_hready <= 1'b0;
                        ds_hresp  <= HRESP_ERROR;
                    end else begin
                        state     <= DS_IDLE;
                        ds_hready <= 1'b1;
                        ds_hresp  <= HRESP_OKAY;
                    end
                end
                default: begin
                    state     <= DS_IDLE;
                    ds_hready <= 1'b1;
                    ds_hresp  <= HRESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: rtl/mfp_ahb_lite_interconnect.sv
// Single-master AHB-Lite decode and response mux for N_SLAVES.
// MFP_AHB_LITE_INTERCONNECT_TIMEOUT_EN enables the stall timeout.
module mfp_ahb_lite_interconnect
    import mfp_ahb_lite_pkg::*;
#(
    parameter int N_SLAVES = 3,
    parameter logic [N_SLAVES*32-1:0] SLAVE_BASE =
        {32'h1F800000, 32'h00000000, 32'h1FC00000},
    parameter logic [N_SLAVES*32-1:0] SLAVE_MASK =
        {32'h1FC00000, 32'h10000000, 32'h1FC00000},
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    output logic [31:0]           HRDATA,
    output logic                  HREADY,
    output logic                  HRESP,
    output logic [N_SLAVES-1:0]   S_HSEL,
    input  logic [N_SLAVES-1:0]   S_HREADYOUT,
    input  logic [N_SLAVES*32-1:0] S_HRDATA,
    input  logic [N_SLAVES-1:0]   S_HRESP
);

    localparam logic [N_SLAVES:0] DSEL_DEF =
        {1'b1, {N_SLAVES{1'b0}}};

    logic [N_SLAVES-1:0] match;
    logic [N_SLAVES-1:0] sel;
    logic [N_SLAVES:0]   dsel;
    logic                active;
    logic                mapped;
    logic                err_req;
    logic                ds_hready;
    logic                ds_hresp;

    for (genvar i = 0; i < N_SLAVES; i++) begin : g_dec
        assign match[i] =
            (HADDR & SLAVE_MASK[32*i +: 32])
            == SLAVE_BASE[32*i +: 32];
    end

    // Isolate lowest set bit: lowest index wins on overlap
    assign sel     = match & (~match + 1'b1);
    assign S_HSEL  = sel;
    assign mapped  = |match;
    assign active  = (HTRANS == HTRANS_NONSEQ)
                  || (HTRANS == HTRANS_SEQ);
    assign err_req = active && !mapped;

`ifdef MFP_AHB_LITE_INTERCONNECT_TIMEOUT_EN
    logic timeout;
    logic timed_out;
    logic slave_stall;

    assign slave_stall = (|dsel[N_SLAVES-1:0]) && !HREADY;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel <= '0;
`ifdef MFP_AHB_LITE_INTERCONNECT_TIMEOUT_EN
        end else if (timeout) begin
            dsel <= DSEL_DEF;
`endif
        end else if (HREADY) begin
            if (!active)
                dsel <= '0;
            else if (mapped)
                dsel <= {1'b0, sel};
            else
                dsel <= DSEL_DEF;
        end
    end

    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (dsel[i]) begin
                HRDATA = S_HRDATA[32*i +: 32];
                HREADY = S_HREADYOUT[i];
                HRESP  = S_HRESP[i];
            end
        end
        if (dsel[N_SLAVES]) begin
            HREADY = ds_hready;
            HRESP  = ds_hresp;
        end
    end

    mfp_ahb_lite_default_slave
`ifdef MFP_AHB_LITE_INTERCONNECT_TIMEOUT_EN
    #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    )
`endif
    u_default (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .hready      (HREADY),
        .err_req     (err_req),
`ifdef MFP_AHB_LITE_INTERCONNECT_TIMEOUT_EN
        .slave_stall (slave_stall),
        .timeout     (timeout),
        .timed_out   (timed_out),
`endif
        .ds_hready   (ds_hready),
        .ds_hresp    (ds_hresp)
    );

endmodule
